// File: rtl/tour_pkg.sv
// Shared types, opcodes and encodings for the knight-tour command sequencer.
// encode_move() builds the 16-bit RemoteComm word for one queued move.
package tour_pkg;

  typedef enum logic [1:0] {
    HEAD_N = 2'b00,
    HEAD_W = 2'b01,
    HEAD_S = 2'b10,
    HEAD_E = 2'b11
  } heading_t;

  typedef struct packed {
    logic       fanfare;
    heading_t   hdg;
    logic [3:0] sq;
  } mv_t;

  localparam logic [3:0] OP_CAL  = 4'h0;
  localparam logic [2:0] OP_MOVE = 3'b001;
  localparam logic [7:0] ACK     = 8'hA5;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_RESP = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_RESP,
    ST_HALT
  } state_t;

  function automatic logic [15:0] encode_move(input mv_t m);
    logic [7:0] hdg8;
    hdg8 = HDG_N;
    case (m.hdg)
      HEAD_N:  hdg8 = HDG_N;
      HEAD_W:  hdg8 = HDG_W;
      HEAD_S:  hdg8 = HDG_S;
      HEAD_E:  hdg8 = HDG_E;
      default: hdg8 = HDG_N;
    endcase
    return {OP_MOVE, m.fanfare, hdg8, m.sq};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read: rdata_o is valid whenever !empty_o,
// so the consumer can pop and use the head entry in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Knight-tour command sequencer: queues move requests, issues one RemoteComm
// command at a time, checks each response for ACK and halts on error/timeout.
module tour_cmd_seq
  import tour_pkg::*;
#(
  parameter int               FIFO_DEPTH = 4,
  parameter int               TMO_W      = 24,
  parameter logic [TMO_W-1:0] TMO_CYC    = 24'hFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mv_vld,
  output logic        mv_rdy,
  input  logic        mv_fanfare,
  input  logic [1:0]  mv_hdg,
  input  logic [3:0]  mv_sq,
  input  logic        cal_req,
  output logic [15:0] cmd,
  output logic        send_cmd,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        busy,
  output logic [7:0]  done_cnt,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - 1'b1;

  state_t           state_q, state_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             send_q, send_d;
  logic             cal_pend_q, cal_pend_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  mv_t  mv_in, mv_head;
  logic fifo_full, fifo_empty, fifo_pop;

  assign mv_in  = mv_t'({mv_fanfare, mv_hdg, mv_sq});
  assign mv_rdy = !fifo_full;

  sync_fifo #(
    .WIDTH ($bits(mv_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_mv_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (mv_vld),
    .pop_i   (fifo_pop),
    .wdata_i (mv_in),
    .rdata_o (mv_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      send_q     <= 1'b0;
      cal_pend_q <= 1'b0;
      tmo_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      send_q     <= send_d;
      cal_pend_q <= cal_pend_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    send_d     = 1'b0;
    cal_pend_d = cal_pend_q | cal_req;
    tmo_d      = tmo_q;
    done_d     = done_q;
    err_d      = err_q;
    code_d     = code_q;
    fifo_pop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!err_q) begin
          if (cal_pend_q) begin
            cmd_d      = {OP_CAL, 12'h000};
            cal_pend_d = cal_req;
            state_d    = ST_SEND;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cmd_d    = encode_move(mv_head);
            state_d  = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        send_d  = 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT_SENT;
      end
      ST_WAIT_SENT: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          code_d  = ERR_TMO;
          state_d = ST_HALT;
        end else if (cmd_sent) begin
          state_d = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        tmo_d = tmo_q + 1'b1;
        // A response arriving on the terminal count still counts.
        if (resp_rdy) begin
          if (resp == ACK) begin
            done_d  = done_q + 8'd1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_RESP;
            state_d = ST_HALT;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          code_d  = ERR_TMO;
          state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd      = cmd_q;
  assign send_cmd = send_q;
  assign busy     = (state_q == ST_SEND) || (state_q == ST_WAIT_SENT) ||
                    (state_q == ST_WAIT_RESP);
  assign done_cnt = done_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq: expected command words are queued as moves
// are pushed and popped/compared whenever the sequencer issues send_cmd.
module tb_tour_cmd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mv_vld = 1'b0;
  logic        mv_rdy;
  logic        mv_fanfare = 1'b0;
  logic [1:0]  mv_hdg = 2'b00;
  logic [3:0]  mv_sq = 4'h0;
  logic        cal_req = 1'b0;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        busy;
  logic [7:0]  done_cnt;
  logic        err;
  logic [1:0]  err_code;

  int          checks = 0;
  int          failures = 0;
  int          exp_done = 0;
  logic [15:0] exp_q [$];

  tour_cmd_seq #(
    .FIFO_DEPTH (4),
    .TMO_W      (24),
    .TMO_CYC    (24'd100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mv_vld     (mv_vld),
    .mv_rdy     (mv_rdy),
    .mv_fanfare (mv_fanfare),
    .mv_hdg     (mv_hdg),
    .mv_sq      (mv_sq),
    .cal_req    (cal_req),
    .cmd        (cmd),
    .send_cmd   (send_cmd),
    .cmd_sent   (cmd_sent),
    .resp_rdy   (resp_rdy),
    .resp       (resp),
    .busy       (busy),
    .done_cnt   (done_cnt),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic f, input logic [1:0] h, input logic [3:0] s);
    logic [7:0] h8;
    case (h)
      2'd0:    h8 = 8'h00;
      2'd1:    h8 = 8'h3F;
      2'd2:    h8 = 8'h7F;
      default: h8 = 8'hBF;
    endcase
    return {3'b001, f, h8, s};
  endfunction

  task automatic push_mv(input logic f, input logic [1:0] h, input logic [3:0] s);
    int n = 0;
    mv_fanfare = f;
    mv_hdg     = h;
    mv_sq      = s;
    mv_vld     = 1'b1;
    while (!mv_rdy && n < 50) begin
      tick();
      n++;
    end
    chk("push_rdy", 32'(mv_rdy), 32'd1);
    tick();
    mv_vld = 1'b0;
    exp_q.push_back(enc(f, h, s));
    $display("push  f=%0d hdg=%0d sq=%0d exp_cmd=%h", f, h, s, enc(f, h, s));
  endtask

  task automatic wait_send();
    int n = 0;
    logic [15:0] e;
    while (!send_cmd && n < 50) begin
      tick();
      n++;
    end
    chk("send_seen", 32'(send_cmd), 32'd1);
    if (send_cmd) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_send", exp_q.size(), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("cmd_word", 32'(cmd), 32'(e));
        $display("send  cmd=%h exp=%h", cmd, e);
      end
    end
  endtask

  task automatic respond(input logic [7:0] r);
    cmd_sent = 1'b1;
    tick();
    cmd_sent = 1'b0;
    chk("no_send_before_resp", 32'(send_cmd), 32'd0);
    chk("busy_in_flight", 32'(busy), 32'd1);
    resp     = r;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    resp     = 8'h00;
    if (r == 8'hA5) exp_done++;
    $display("resp  byte=%h done_cnt=%0d exp_done=%0d", r, done_cnt, exp_done);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (send_cmd) seen++;
    end
    chk(tag, seen, 32'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    mv_vld   = 1'b0;
    cal_req  = 1'b0;
    cmd_sent = 1'b0;
    resp_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_done = 0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_mv_rdy", 32'(mv_rdy), 32'd1);
    chk("rst_send", 32'(send_cmd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);

    // Calibrate first, then N2
    cal_req = 1'b1;
    exp_q.push_back(16'h0000);
    tick();
    cal_req = 1'b0;
    push_mv(1'b0, 2'd0, 4'd2);
    wait_send();
    respond(8'hA5);
    wait_send();
    respond(8'hA5);
    chk("cal_done", 32'(done_cnt), 32'(exp_done));
    chk("cal_err", 32'(err), 32'd0);
    chk("cal_code", 32'(err_code), 32'd0);

    // E2 with latency check, then S4, W2, N4 queued behind it
    push_mv(1'b0, 2'd3, 4'd2);
    chk("lat_idle", 32'(send_cmd), 32'd0);
    tick();
    chk("lat_send_state", 32'(send_cmd), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_pulse", 32'(send_cmd), 32'd1);
    wait_send();
    push_mv(1'b0, 2'd2, 4'd4);
    push_mv(1'b0, 2'd1, 4'd2);
    push_mv(1'b0, 2'd0, 4'd4);
    respond(8'hA5);
    for (int i = 0; i < 3; i++) begin
      wait_send();
      respond(8'hA5);
    end
    chk("seq_done", 32'(done_cnt), 32'(exp_done));

    // ACK on the terminal timeout cycle wins
    push_mv(1'b1, 2'd0, 4'd1);
    wait_send();
    cmd_sent = 1'b1;
    tick();
    cmd_sent = 1'b0;
    repeat (98) tick();
    chk("term_noerr_before", 32'(err), 32'd0);
    resp     = 8'hA5;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    exp_done++;
    $display("resp  terminal-cycle ack done_cnt=%0d err=%0d", done_cnt, err);
    chk("term_done", 32'(done_cnt), 32'(exp_done));
    chk("term_err", 32'(err), 32'd0);
    chk("term_busy", 32'(busy), 32'd0);

    // Bad response on the second command
    do_reset();
    chk("rst2_done", 32'(done_cnt), 32'd0);
    push_mv(1'b0, 2'd1, 4'd1);
    push_mv(1'b1, 2'd2, 4'd3);
    wait_send();
    respond(8'hA5);
    wait_send();
    respond(8'h5A);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_code", 32'(err_code), 32'd1);
    chk("bad_done", 32'(done_cnt), 32'(exp_done));
    chk("bad_busy", 32'(busy), 32'd0);
    push_mv(1'b0, 2'd0, 4'd5);
    quiet("bad_no_send", 10);

    // Reset while waiting for a response with two moves queued
    do_reset();
    push_mv(1'b0, 2'd0, 4'd1);
    push_mv(1'b0, 2'd1, 4'd2);
    push_mv(1'b0, 2'd2, 4'd3);
    wait_send();
    cmd_sent = 1'b1;
    tick();
    cmd_sent = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_done = 0;
    chk("mid_rst_mv_rdy", 32'(mv_rdy), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done_cnt), 32'd0);
    chk("mid_rst_send0", 32'(send_cmd), 32'd0);
    tick();
    chk("mid_rst_send1", 32'(send_cmd), 32'd0);
    tick();
    chk("mid_rst_send2", 32'(send_cmd), 32'd0);
    quiet("mid_rst_queue_empty", 8);

    // Five moves with no responses: one in flight, four fill the queue
    push_mv(1'b0, 2'd3, 4'd1);
    wait_send();
    for (int i = 0; i < 4; i++) push_mv(1'(i), 2'(i), 4'(i + 2));
    chk("full_mv_rdy", 32'(mv_rdy), 32'd0);
    mv_fanfare = 1'b1;
    mv_hdg     = 2'd3;
    mv_sq      = 4'hF;
    mv_vld     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_refuse", 32'(mv_rdy), 32'd0);
      tick();
    end
    mv_vld = 1'b0;
    respond(8'hA5);
    for (int i = 0; i < 4; i++) begin
      wait_send();
      respond(8'hA5);
    end
    quiet("full_no_extra", 10);
    chk("full_done", 32'(done_cnt), 32'(exp_done));
    chk("full_exp_drained", exp_q.size(), 32'd0);

    // Response timeout
    push_mv(1'b0, 2'd2, 4'd6);
    wait_send();
    cmd_sent = 1'b1;
    tick();
    cmd_sent = 1'b0;
    repeat (98) tick();
    chk("tmo_not_yet", 32'(err), 32'd0);
    tick();
    $display("tmo   err=%0d err_code=%0d busy=%0d", err, err_code, busy);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_code", 32'(err_code), 32'd2);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_done", 32'(done_cnt), 32'(exp_done));
    push_mv(1'b0, 2'd1, 4'd7);
    quiet("tmo_no_send", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
